merge_field_scheduler: RTL and testbench

- Read-modify-write sequencer and two-port arbiter for the CPU shift/merge bit-field unit (LBD/RBD byte latches).
- Accepts field-write requests (latch select, bit position, field length, data) from two requesters: 0 = CPU pipeline, 1 = ROM-programmer control.
- Drives the shift/merge unit's control inputs as a two-stage LOAD/WRITE pipeline.
- Honours data_hazard stalls and blocks same-latch read-after-write hazards.

---
 rtl/merge_field_scheduler_pkg.sv | 31 +++
 rtl/merge_field_scheduler_arbiter.sv | 42 ++++
 rtl/merge_field_scheduler.sv | 120 ++++++++++++
 tb/tb_merge_field_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_field_scheduler_pkg.sv
// Shared constants and stage record for the shift/merge field-write scheduler.
// Imported by the arbiter and the top.
package merge_field_scheduler_pkg;

  localparam logic LAT_LBD  = 1'b0;
  localparam logic LAT_RBD  = 1'b1;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_PROG = 1'b1;

  localparam int POS_W  = 3;
  localparam int LEN_W  = 3;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic              addr;
    logic [POS_W-1:0]  pos;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              id;
  } stage_t;

  localparam stage_t STAGE_IDLE = '0;

  // A same-latch op must wait until its predecessor has left the LOAD stage.
  function automatic logic req_eligible(input logic valid, input logic addr, input stage_t l_stage);
    return valid & ~(l_stage.valid & (l_stage.addr == addr));
  endfunction

endpackage

// File: rtl/merge_field_scheduler_arbiter.sv
// Two-way grant logic, fixed priority or round-robin, choosing only among eligible requesters.
// The round-robin pointer remembers the last granted requester and moves only on a transfer.
module merge_req_arbiter
  import merge_field_scheduler_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  input  logic i_elig0,
  input  logic i_elig1,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_last;
  logic w_prefer1;

  always_comb begin
    w_prefer1 = (ARB_MODE == 1) ? ~r_last : 1'b0;
    o_grant0  = 1'b0;
    o_grant1  = 1'b0;
    if (w_prefer1) begin
      o_grant1 = i_elig1;
      o_grant0 = i_elig0 & ~i_elig1;
    end else begin
      o_grant0 = i_elig0;
      o_grant1 = i_elig1 & ~i_elig0;
    end
  end

  // Reset to the programmer side so the CPU is preferred on the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_PROG;
    end else if (!i_stall && (o_grant0 || o_grant1)) begin
      r_last <= o_grant1;
    end
  end

endmodule

// File: rtl/merge_field_scheduler.sv
// LOAD/WRITE sequencer for the LBD/RBD shift/merge unit with a two-port requester front end.
// Outputs decode from the L and W stage registers only; ready is the sole combinational output.
module merge_field_scheduler
  import merge_field_scheduler_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_hazard,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_addr,
  input  logic [POS_W-1:0]  req0_pos,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_addr,
  input  logic [POS_W-1:0]  req1_pos,
  input  logic [LEN_W-1:0]  req1_len,
  input  logic [DATA_W-1:0] req1_data,
  output logic [DATA_W-1:0] shift_in,
  output logic [LEN_W-1:0]  L_select,
  output logic              latch_address_r,
  output logic [POS_W-1:0]  D0,
  output logic              latch_wren,
  output logic              latch_address_w,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  stage_t r_l;
  stage_t r_w;
  logic   r_done;
  logic   r_done_id;

  logic   w_elig0;
  logic   w_elig1;
  logic   w_grant0;
  logic   w_grant1;
  stage_t w_req;
  logic   w_unused_w;

  assign w_elig0 = req_eligible(req0_valid, req0_addr, r_l);
  assign w_elig1 = req_eligible(req1_valid, req1_addr, r_l);

  merge_req_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stall  (data_hazard),
    .i_elig0  (w_elig0),
    .i_elig1  (w_elig1),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  assign req0_ready = w_grant0 & ~data_hazard;
  assign req1_ready = w_grant1 & ~data_hazard;

  always_comb begin
    w_req = STAGE_IDLE;
    if (w_grant0) begin
      w_req = '{valid: 1'b1, addr: req0_addr, pos: req0_pos, len: req0_len,
                data: req0_data, id: REQ_CPU};
    end else if (w_grant1) begin
      w_req = '{valid: 1'b1, addr: req1_addr, pos: req1_pos, len: req1_len,
                data: req1_data, id: REQ_PROG};
    end
  end

  // A stall freezes both stages and done_id; done is a single-cycle pulse so it clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l       <= STAGE_IDLE;
      r_w       <= STAGE_IDLE;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else if (data_hazard) begin
      r_done    <= 1'b0;
    end else begin
      r_w    <= r_l;
      r_l    <= w_req;
      r_done <= r_w.valid;
      if (r_w.valid) begin
        r_done_id <= r_w.id;
      end
    end
  end

  always_comb begin
    shift_in        = '0;
    L_select        = '0;
    latch_address_r = 1'b0;
    D0              = '0;
    latch_wren      = 1'b0;
    latch_address_w = 1'b0;
    if (r_l.valid) begin
      shift_in        = r_l.data;
      L_select        = r_l.len;
      latch_address_r = r_l.addr;
    end
    if (r_w.valid) begin
      latch_wren      = 1'b1;
      D0              = r_w.pos;
      latch_address_w = r_w.addr;
    end
  end

  assign busy       = r_l.valid | r_w.valid;
  assign done       = r_done;
  assign done_id    = r_done_id;

  // The merge unit already holds length and data by the time W drives it.
  assign w_unused_w = ^{r_w.len, r_w.data};

endmodule

// File: tb/tb_merge_field_scheduler.sv
// Directed bench: scheduler plus a behavioural shift/merge unit holding the LBD/RBD latches.
// A second instance in fixed-priority mode shares the stimulus to contrast the arbiters.
module tb_merge_field_scheduler;
  import merge_field_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_hazard = 1'b0;
  logic       req0_valid = 1'b0, req0_addr = 1'b0;
  logic [2:0] req0_pos = '0, req0_len = '0;
  logic [7:0] req0_data = '0;
  logic       req1_valid = 1'b0, req1_addr = 1'b0;
  logic [2:0] req1_pos = '0, req1_len = '0;
  logic [7:0] req1_data = '0;

  logic       req0_ready, req1_ready, latch_address_r, latch_wren, latch_address_w;
  logic       busy, done, done_id;
  logic [7:0] shift_in;
  logic [2:0] L_select, D0;

  logic       fp_req0_ready, fp_req1_ready, fp_latch_address_r, fp_latch_wren, fp_latch_address_w;
  logic       fp_busy, fp_done, fp_done_id;
  logic [7:0] fp_shift_in;
  logic [2:0] fp_L_select, fp_D0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  merge_field_scheduler #(.ARB_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_hazard(data_hazard),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_pos(req0_pos), .req0_len(req0_len), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_pos(req1_pos), .req1_len(req1_len), .req1_data(req1_data),
    .shift_in(shift_in), .L_select(L_select), .latch_address_r(latch_address_r),
    .D0(D0), .latch_wren(latch_wren), .latch_address_w(latch_address_w),
    .busy(busy), .done(done), .done_id(done_id)
  );

  merge_field_scheduler #(.ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .data_hazard(data_hazard),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_addr(req0_addr),
    .req0_pos(req0_pos), .req0_len(req0_len), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_addr(req1_addr),
    .req1_pos(req1_pos), .req1_len(req1_len), .req1_data(req1_data),
    .shift_in(fp_shift_in), .L_select(fp_L_select), .latch_address_r(fp_latch_address_r),
    .D0(fp_D0), .latch_wren(fp_latch_wren), .latch_address_w(fp_latch_address_w),
    .busy(fp_busy), .done(fp_done), .done_id(fp_done_id)
  );

  // Behavioural merge unit: captures operand at LOAD, writes the field at WRITE.
  logic [7:0] lat [2];
  logic [7:0] m_data, m_in;
  logic [2:0] m_len;

  function automatic logic [7:0] fmerge(input logic [7:0] old, input logic [7:0] d,
                                        input logic [2:0] len, input logic [2:0] pos);
    logic [15:0] mask;
    logic [15:0] sd;
    mask = ((len == 3'd0) ? 16'h00FF : ((16'h1 << len) - 16'h1)) << pos;
    sd   = {8'h00, d} << pos;
    return (old & ~mask[7:0]) | (sd[7:0] & mask[7:0]);
  endfunction

  always @(posedge clk) begin
    if (!data_hazard) begin
      if (latch_wren) lat[latch_address_w] <= fmerge(m_in, m_data, m_len, D0);
      m_data <= shift_in;
      m_len  <= L_select;
      m_in   <= lat[latch_address_r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drv0(input logic v, input logic a, input logic [2:0] p, input logic [2:0] l,
                      input logic [7:0] d);
    req0_valid = v; req0_addr = a; req0_pos = p; req0_len = l; req0_data = d;
  endtask

  task automatic drv1(input logic v, input logic a, input logic [2:0] p, input logic [2:0] l,
                      input logic [7:0] d);
    req1_valid = v; req1_addr = a; req1_pos = p; req1_len = l; req1_data = d;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  logic [1:0] rr_tab [5];
  logic [1:0] fp_tab [5];
  int         exp_id [$];
  int         ndone;

  initial begin
    rr_tab = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    fp_tab = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01};

    // Reset state
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", latch_wren, 0);
    chk("rst_shift", shift_in, 0);
    chk("rst_ready0", req0_ready, 0);

    // Same-latch back-to-back: one bubble
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'hFF); #1;
    chk("t1_rdy_a", req0_ready, 1);
    @(negedge clk); drv0(1, LAT_LBD, 3'd2, 3'd3, 8'h05); #1;
    chk("t1_block_same", req0_ready, 0);
    chk("t1_shift_in", shift_in, 8'hFF);
    chk("t1_busy", busy, 1);
    @(negedge clk); #1;
    chk("t1_rdy_b", req0_ready, 1);
    chk("t1_wren", latch_wren, 1);
    chk("t1_d0", D0, 0);
    @(negedge clk); drv0(0, LAT_LBD, 3'd0, 3'd0, 8'h00); #1;
    chk("t1_done_a", done, 1);
    chk("t1_lbd_a", lat[0], 8'hFF);
    @(negedge clk); #1;
    chk("t1_bubble", done, 0);
    @(negedge clk); #1;
    chk("t1_done_b", done, 1);
    chk("t1_lbd_b", lat[0], 8'hF7);

    // Alternating latches at full rate
    @(negedge clk); drv0(1, LAT_RBD, 3'd0, 3'd0, 8'h00); #1;
    @(negedge clk); drv0(0, LAT_RBD, 3'd0, 3'd0, 8'h00);
    wait_done("t2_preset", 8);
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h3C); #1;
    chk("t2_rdy_a", req0_ready, 1);
    @(negedge clk); drv0(1, LAT_RBD, 3'd4, 3'd4, 8'h0A); #1;
    chk("t2_rdy_b", req0_ready, 1);
    @(negedge clk); drv0(0, LAT_LBD, 3'd0, 3'd0, 8'h00); #1;
    @(negedge clk); #1;
    chk("t2_done_a", done, 1);
    chk("t2_id_a", done_id, 0);
    @(negedge clk); #1;
    chk("t2_done_b", done, 1);
    chk("t2_data_out", {lat[0], lat[1]}, 16'h3CA0);

    // Both requesters on different latches; round-robin pointer last saw requester 0
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h12);
        drv1(1, LAT_RBD, 3'd0, 3'd0, 8'h34);
      end
      if (i == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (i < 6) begin
        chk($sformatf("t3_rr_rdy%0d", i), {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("t3_fp_rdy%0d", i), {fp_req0_ready, fp_req1_ready},
            (i % 2 == 0) ? 2'b10 : 2'b01);
        exp_id.push_back((i % 2 == 0) ? 1 : 0);
      end
      if (i >= 3) begin
        chk($sformatf("t3_done%0d", i), done, 1);
        chk($sformatf("t3_done_id%0d", i), done_id, exp_id[i-3]);
      end
    end

    // Both requesters on the same latch: fixed priority starves requester 1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h56);
        drv1(1, LAT_LBD, 3'd0, 3'd0, 8'h78);
      end
      if (i == 4) req0_valid = 1'b0;
      #1;
      chk($sformatf("t3s_rr_rdy%0d", i), {req0_ready, req1_ready}, rr_tab[i]);
      chk($sformatf("t3s_fp_rdy%0d", i), {fp_req0_ready, fp_req1_ready}, fp_tab[i]);
    end
    @(negedge clk); idle(6);

    // Same-latch conflict: ineligible requester never blocks the other
    @(negedge clk); drv1(1, LAT_RBD, 3'd0, 3'd0, 8'h11); #1;
    chk("t4_rdy1_first", req1_ready, 1);
    @(negedge clk); drv0(1, LAT_RBD, 3'd0, 3'd0, 8'h22); drv1(1, LAT_LBD, 3'd0, 3'd0, 8'h33); #1;
    chk("t4_rdy0_blocked", req0_ready, 0);
    chk("t4_rdy1_other", req1_ready, 1);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("t4_rdy0_next", req0_ready, 1);
    @(negedge clk); idle(6); #1;
    chk("t4_latches", {lat[0], lat[1]}, 16'h3322);

    // Three-cycle stall with L and W both occupied
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h5A); #1;
    chk("t5_rdy_a", req0_ready, 1);
    @(negedge clk); drv0(1, LAT_RBD, 3'd0, 3'd0, 8'hC3); #1;
    chk("t5_rdy_b", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0; drv1(1, LAT_LBD, 3'd1, 3'd2, 8'h03); data_hazard = 1'b1; #1;
    chk("t5_stall_rdy", req1_ready, 0);
    chk("t5_stall_wren", latch_wren, 1);
    chk("t5_stall_shift", shift_in, 8'hC3);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_frz_wren%0d", s), latch_wren, 1);
      chk($sformatf("t5_frz_raddr%0d", s), latch_address_r, 1);
      chk($sformatf("t5_frz_done%0d", s), done, 0);
      chk($sformatf("t5_frz_rdy%0d", s), req1_ready, 0);
    end
    @(negedge clk); data_hazard = 1'b0; req1_valid = 1'b0; #1;
    chk("t5_resume_nodone", done, 0);
    @(negedge clk); #1;
    chk("t5_done_a", done, 1);
    chk("t5_lbd", lat[0], 8'h5A);
    @(negedge clk); #1;
    chk("t5_done_b", done, 1);
    chk("t5_rbd", lat[1], 8'hC3);
    @(negedge clk); idle(4);

    // Asynchronous reset mid-cycle with both stages valid
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h77); #1;
    @(negedge clk); drv0(1, LAT_RBD, 3'd0, 3'd0, 8'h66); #1;
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h55); #1;
    chk("t6_rdy_c", req0_ready, 1);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("t6_pre_done", done, 1);
    chk("t6_pre_wren", latch_wren, 1);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_wren", latch_wren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_shift", shift_in, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (done) ndone++;
    end
    chk("t6_dropped_nodone", ndone, 0);
    @(negedge clk); drv0(1, LAT_LBD, 3'd0, 3'd0, 8'h81); #1;
    chk("t6_rdy_new", req0_ready, 1);
    @(negedge clk); req0_valid = 1'b0;
    wait_done("t6_done_new", 8);
    chk("t6_readback", lat[0], 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
